// File: rtl/mac_filter_scheduler_if.sv
// Frame-stream, filter-config, comparator and result signals of mac_filter_scheduler.
// The scheduler takes the slave modport; the environment (source, config, comparator) takes master.
interface mac_filter_scheduler_if #(
    parameter int IDX_W = 2,
    parameter int TGT_W = 32
);
    logic             in_valid;
    logic             in_sof;
    logic [31:0]      in_data;
    logic             in_ready;

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [TGT_W-1:0] cfg_target;
    logic             cfg_enable;

    logic             comp_clear;
    logic [TGT_W-1:0] comp_target;
    logic [31:0]      comp_data;
    logic             comp_match;

    logic             res_valid;
    logic             res_hit;
    logic [IDX_W-1:0] res_idx;
    logic             busy;

    modport master (
        output in_valid, in_sof, in_data, cfg_we, cfg_idx, cfg_target, cfg_enable, comp_match,
        input  in_ready, comp_clear, comp_target, comp_data, res_valid, res_hit, res_idx, busy
    );

    modport slave (
        input  in_valid, in_sof, in_data, cfg_we, cfg_idx, cfg_target, cfg_enable, comp_match,
        output in_ready, comp_clear, comp_target, comp_data, res_valid, res_hit, res_idx, busy
    );
endinterface

// File: rtl/mac_filter_scheduler.sv
// Captures a frame header and replays it once per enabled filter entry through a shared comparator.
// Optional MAC_FILT_DROP_CNT_EN adds a saturating drop_cnt of frames offered while not ready.
module mac_filter_scheduler #(
    parameter int NUM_FILT  = 4,
    parameter int HDR_WORDS = 4,
    parameter int TGT_W     = 32,
    parameter int COMP_LAT  = 2
) (
    input  logic clk,
    input  logic rst,
    mac_filter_scheduler_if.slave bus
`ifdef MAC_FILT_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);
    localparam int IDX_W   = $clog2(NUM_FILT);
    localparam int CNT_MAX = (HDR_WORDS > COMP_LAT) ? HDR_WORDS : COMP_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_CLEAR   = 3'd2;
    localparam logic [2:0] S_REPLAY  = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [31:0]      hdr_buf [HDR_WORDS];
    logic [TGT_W-1:0] tbl_target [NUM_FILT];
    logic [NUM_FILT-1:0] tbl_en;
    logic [TGT_W-1:0] target_q;
    logic             hit_q;
    logic [IDX_W-1:0] idx_q;

    logic             cfg_ok;
    logic             first_found, next_found;
    logic [IDX_W-1:0] first_idx, next_idx;

    assign cfg_ok = bus.cfg_we && (32'(bus.cfg_idx) < NUM_FILT);

    // Priority search: lowest enabled entry overall, and lowest enabled entry above ptr.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_FILT - 1; i >= 0; i--) begin
            if (tbl_en[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (tbl_en[i] && (i > int'(ptr))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    // NOTE: header buffer and target table are plain storage with no reset; only enables are cleared.
    always_ff @(posedge clk) begin
        if (bus.in_valid && ((state == S_IDLE && bus.in_sof) || state == S_CAPTURE))
            hdr_buf[bus.in_sof ? '0 : cnt] <= bus.in_data;
        if (cfg_ok)
            tbl_target[bus.cfg_idx] <= bus.cfg_target;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            tbl_en   <= '0;
            target_q <= '0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            if (cfg_ok)
                tbl_en[bus.cfg_idx] <= bus.cfg_enable;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_sof) begin
                        state <= S_CAPTURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (bus.in_valid) begin
                        if (bus.in_sof) begin
                            cnt <= CNT_W'(1);
                        end else if (cnt == CNT_W'(HDR_WORDS - 1)) begin
                            cnt <= '0;
                            if (first_found) begin
                                state    <= S_CLEAR;
                                ptr      <= first_idx;
                                target_q <= tbl_target[first_idx];
                            end else begin
                                state <= S_DONE;
                                hit_q <= 1'b0;
                                idx_q <= '0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    state <= S_REPLAY;
                    cnt   <= '0;
                end
                S_REPLAY: begin
                    if (cnt == CNT_W'(HDR_WORDS - 1)) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(COMP_LAT - 1)) begin
                        cnt <= '0;
                        if (bus.comp_match) begin
                            state <= S_DONE;
                            hit_q <= 1'b1;
                            idx_q <= ptr;
                        end else if (next_found) begin
                            state    <= S_CLEAR;
                            ptr      <= next_idx;
                            target_q <= tbl_target[next_idx];
                        end else begin
                            state <= S_DONE;
                            hit_q <= 1'b0;
                            idx_q <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAC_FILT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (bus.in_valid && bus.in_sof && !bus.in_ready && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    // Ready is masked by rst so it reads 0 for the whole reset window.
    assign bus.in_ready    = !rst && (state == S_IDLE || state == S_CAPTURE);
    assign bus.comp_clear  = (state == S_CLEAR) || (state == S_DONE);
    assign bus.comp_target = target_q;
    assign bus.comp_data   = (state == S_REPLAY) ? hdr_buf[cnt] : 32'd0;
    assign bus.res_valid   = (state == S_DONE);
    assign bus.res_hit     = hit_q;
    assign bus.res_idx     = idx_q;
    assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_mac_filter_scheduler.sv
// Self-checking bench for mac_filter_scheduler: directed steps plus randomized frames/tables,
// checked against a frame-level reference model; honours MAC_FILT_DROP_CNT_EN.
module tb_mac_filter_scheduler;
    localparam int NUM_FILT = 4;
    localparam int HDR      = 4;
    localparam int TGT_W    = 32;
    localparam int COMP_LAT = 2;
    localparam int IDX_W    = 2;
    localparam int S        = 1 + HDR + COMP_LAT;

    typedef logic [31:0] word_t;
    typedef word_t frame_t [HDR];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    mac_filter_scheduler_if #(.IDX_W(IDX_W), .TGT_W(TGT_W)) bus ();
`ifdef MAC_FILT_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    mac_filter_scheduler #(
        .NUM_FILT(NUM_FILT), .HDR_WORDS(HDR), .TGT_W(TGT_W), .COMP_LAT(COMP_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef MAC_FILT_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    // Little-endian byte stream search: target found at any byte alignment.
    function automatic bit contains(input word_t q[$], input word_t tgt);
        byte unsigned b[$];
        foreach (q[i])
            for (int k = 0; k < 4; k++) b.push_back(q[i][8*k +: 8]);
        for (int o = 0; o + 4 <= b.size(); o++)
            if ({b[o+3], b[o+2], b[o+1], b[o]} == tgt) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit hist_match(input word_t h[HDR], input int n, input word_t d, input word_t tgt);
        word_t q[$];
        for (int i = 0; i < n; i++) q.push_back(h[i]);
        q.push_back(d);
        return contains(q, tgt);
    endfunction

    // Behavioural comparator: accumulates the HDR words following each clear, sticky match.
    word_t cmp_hist [HDR];
    int    cmp_n    = 0;
    int    cmp_left = 0;
    always @(posedge clk) begin
        if (rst || bus.comp_clear) begin
            cmp_n          <= 0;
            cmp_left       <= rst ? 0 : HDR;
            bus.comp_match <= 1'b0;
        end else if (cmp_left > 0) begin
            cmp_hist[cmp_n] <= bus.comp_data;
            cmp_n           <= cmp_n + 1;
            cmp_left        <= cmp_left - 1;
            if (hist_match(cmp_hist, cmp_n, bus.comp_data, bus.comp_target))
                bus.comp_match <= 1'b1;
        end
    end

    // Reference filter table as seen by the bench.
    word_t m_tgt [NUM_FILT];
    bit    m_en  [NUM_FILT];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int idx, input word_t tgt, input bit en);
        @(negedge clk);
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = IDX_W'(idx);
        bus.cfg_target = tgt;
        bus.cfg_enable = en;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        m_tgt[idx] = tgt;
        m_en[idx]  = en;
    endtask

    // Sends the first n words; t is the cycle the last word was offered. Returns at t+1.
    task automatic send_frame(input frame_t f, input int n, output int t);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sof   = (i == 0);
            bus.in_data  = f[i];
        end
        t = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic predict(input frame_t f, output bit hit, output int idx, output int k);
        word_t fq[$];
        foreach (f[i]) fq.push_back(f[i]);
        hit = 1'b0;
        idx = 0;
        k   = 0;
        for (int i = 0; i < NUM_FILT && !hit; i++)
            if (m_en[i]) begin
                k++;
                if (contains(fq, m_tgt[i])) begin
                    hit = 1'b1;
                    idx = i;
                end
            end
    endtask

    // Follows one scan from t+1; optionally offers a sof at t+inj while the scan runs.
    task automatic watch(input string tag, input int t, input bit hit, input int idx,
                         input int k, input int inj);
        int seen     = -1;
        int nclr     = 0;
        bit done_clr = 1'b0;
        for (int n = 0; n < 20 * S && seen < 0; n++) begin
            if (n > 0) @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            if (inj > 0 && cyc == t + inj) begin
                bus.in_valid = 1'b1;
                bus.in_sof   = 1'b1;
                bus.in_data  = $urandom;
            end
            if (bus.res_valid) begin
                seen     = cyc;
                done_clr = bus.comp_clear;
            end else if (bus.comp_clear) begin
                check({tag, ".clear_at"}, 64'(cyc), 64'(t + 1 + nclr * S));
                nclr++;
            end
        end
        check({tag, ".res_at"}, 64'(seen), 64'(t + k * S + 1));
        check({tag, ".hit"}, 64'(bus.res_hit), 64'(hit));
        check({tag, ".idx"}, 64'(bus.res_idx), 64'(idx));
        check({tag, ".nclear"}, 64'(nclr), 64'(k));
        check({tag, ".done_clear"}, 64'(done_clr), 64'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check({tag, ".post_hold_hit"}, 64'(bus.res_hit), 64'(hit));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f2, f3, fr;
        int     t, k, idx, vcount;
        bit     hit;

        bus.in_valid   = 1'b0;
        bus.in_sof     = 1'b0;
        bus.in_data    = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_idx    = '0;
        bus.cfg_target = '0;
        bus.cfg_enable = 1'b0;
        for (int i = 0; i < NUM_FILT; i++) begin
            m_tgt[i] = '0;
            m_en[i]  = 1'b0;
        end

        // Reset held three cycles.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.flags", 64'({bus.in_ready, bus.busy, bus.comp_clear, bus.res_valid, bus.res_hit, bus.res_idx}), 64'(0));
        check("rst.comp_target", 64'(bus.comp_target), 64'(0));
        check("rst.comp_data", 64'(bus.comp_data), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rel.in_ready", 64'(bus.in_ready), 64'(1));
        check("rel.busy", 64'(bus.busy), 64'(0));
`ifdef MAC_FILT_DROP_CNT_EN
        check("rel.drop_cnt", 64'(drop_cnt), 64'(0));
`endif

        // Single hit with the target split across words 0 and 1.
        f2[0] = 32'hC3D4E5F6; f2[1] = 32'h0000A1B2; f2[2] = 32'h0; f2[3] = 32'h0;
        cfg_write(0, 32'hA1B2C3D4, 1'b1);
        predict(f2, hit, idx, k);
        check("hit1.model", 64'({hit, 8'(idx), 8'(k)}), 64'({1'b1, 8'd0, 8'd1}));
        send_frame(f2, HDR, t);
        watch("hit1", t, hit, idx, k, 0);

        // Entries 0 and 2 enabled, only entry 2 matches; entry 1 skipped.
        f3[0] = 32'h11223344; f3[1] = 32'h55667788; f3[2] = 32'h99AABBCC; f3[3] = 32'hDDEEFF00;
        cfg_write(2, 32'hBBCC5566, 1'b1);
        predict(f3, hit, idx, k);
        send_frame(f3, HDR, t);
        watch("skip", t, hit, idx, k, 0);

        // No entries enabled: immediate miss.
        cfg_write(0, 32'hA1B2C3D4, 1'b0);
        cfg_write(2, 32'hBBCC5566, 1'b0);
        foreach (fr[i]) fr[i] = $urandom;
        send_frame(fr, HDR, t);
        watch("none", t, 1'b0, 0, 0, 0);

        // sof offered during REPLAY is dropped; scan result unaffected.
        cfg_write(0, 32'hA1B2C3D4, 1'b1);
        predict(f2, hit, idx, k);
        send_frame(f2, HDR, t);
        watch("drop", t, hit, idx, k, 3);
`ifdef MAC_FILT_DROP_CNT_EN
        check("drop.cnt", 64'(drop_cnt), 64'(1));
`endif
        // Partial frame restarted by a fresh sof, then a complete frame.
        send_frame(f2, 2, t);
        predict(f3, hit, idx, k);
        send_frame(f3, HDR, t);
        watch("restart", t, hit, idx, k, 0);

        // Reset during REPLAY aborts the scan and clears the enables.
        send_frame(f2, HDR, t);
        @(negedge clk);
        @(negedge clk);
        check("abort.busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        #1;
        check("abort.in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_FILT; i++) m_en[i] = 1'b0;
        check("abort.flags", 64'({bus.comp_clear, bus.res_valid, bus.busy}), 64'(0));
        check("abort.comp_target", 64'(bus.comp_target), 64'(0));
`ifdef MAC_FILT_DROP_CNT_EN
        check("abort.drop_cnt", 64'(drop_cnt), 64'(0));
`endif
        vcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.res_valid) vcount++;
        end
        check("abort.no_result", 64'(vcount), 64'(0));
        predict(f2, hit, idx, k);
        send_frame(f2, HDR, t);
        watch("after_rst", t, hit, idx, k, 0);

        // Randomized tables and frames; roughly half the targets are cut from the frame.
        for (int it = 0; it < 8; it++) begin
            foreach (fr[i]) fr[i] = $urandom;
            for (int e = 0; e < NUM_FILT; e++) begin
                word_t       tg;
                logic [63:0] pair;
                int          w, o;
                if ($urandom_range(0, 1) == 1) begin
                    w    = $urandom_range(0, HDR - 2);
                    o    = $urandom_range(0, 3);
                    pair = {fr[w+1], fr[w]};
                    tg   = pair[8*o +: 32];
                end else begin
                    tg = $urandom;
                end
                cfg_write(e, tg, 1'($urandom_range(0, 1)));
            end
            predict(fr, hit, idx, k);
            send_frame(fr, HDR, t);
            watch($sformatf("rnd%0d", it), t, hit, idx, k, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
